range_scan: RTL and testbench



---
 rtl/range_scan.sv | 195 +++++++++++++++++++
 tb/tb_range_scan.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/range_scan.sv
// Reads every count word out of the Collatz range block's RAM after it signals done.
// Each (index, count) pair is streamed out over valid/ready, and the sweep is reduced to max/argmax and min/argmin.
// Optional build macro RANGE_SCAN_SUM_EN adds a 32-bit sum of all counts on sum_count.
module range_scan #(
    parameter int RAM_WORDS     = 16,
    parameter int RAM_ADDR_BITS = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     range_done,
    output logic [RAM_ADDR_BITS-1:0] rd_addr,
    input  logic [15:0]              rd_count,
    output logic                     busy,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [RAM_ADDR_BITS-1:0] out_index,
    output logic [15:0]              out_count,
    output logic                     result_valid,
    output logic [15:0]              max_count,
    output logic [RAM_ADDR_BITS-1:0] max_index,
    output logic [15:0]              min_count,
    output logic [RAM_ADDR_BITS-1:0] min_index
`ifdef RANGE_SCAN_SUM_EN
    ,
    output logic [31:0]              sum_count
`endif
);

    // state     | meaning
    // S_IDLE    | waiting for range_done; results held
    // S_ADDR    | rd_addr driven, RAM read in flight
    // S_PRESENT | element offered downstream until accepted
    // S_FINISH  | accumulators copied to the result outputs
    typedef enum logic [1:0] {
        S_IDLE,
        S_ADDR,
        S_PRESENT,
        S_FINISH
    } state_t;

    localparam logic [RAM_ADDR_BITS-1:0] LAST_IDX = RAM_ADDR_BITS'(RAM_WORDS - 1);
    localparam logic [RAM_ADDR_BITS-1:0] IDX_ONE  = RAM_ADDR_BITS'(1);

    state_t                   state_q, state_d;
    logic [RAM_ADDR_BITS-1:0] idx_q, idx_d;
    logic [15:0]              max_acc_q, max_acc_d;
    logic [RAM_ADDR_BITS-1:0] max_idx_acc_q, max_idx_acc_d;
    logic [15:0]              min_acc_q, min_acc_d;
    logic [RAM_ADDR_BITS-1:0] min_idx_acc_q, min_idx_acc_d;
    logic                     result_valid_q, result_valid_d;
    logic [15:0]              max_count_q, max_count_d;
    logic [RAM_ADDR_BITS-1:0] max_index_q, max_index_d;
    logic [15:0]              min_count_q, min_count_d;
    logic [RAM_ADDR_BITS-1:0] min_index_q, min_index_d;
`ifdef RANGE_SCAN_SUM_EN
    logic [31:0]              sum_acc_q, sum_acc_d;
    logic [31:0]              sum_count_q, sum_count_d;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            idx_q          <= '0;
            max_acc_q      <= '0;
            max_idx_acc_q  <= '0;
            min_acc_q      <= 16'hFFFF;
            min_idx_acc_q  <= '0;
            result_valid_q <= 1'b0;
            max_count_q    <= '0;
            max_index_q    <= '0;
            min_count_q    <= '0;
            min_index_q    <= '0;
`ifdef RANGE_SCAN_SUM_EN
            sum_acc_q      <= '0;
            sum_count_q    <= '0;
`endif
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            max_acc_q      <= max_acc_d;
            max_idx_acc_q  <= max_idx_acc_d;
            min_acc_q      <= min_acc_d;
            min_idx_acc_q  <= min_idx_acc_d;
            result_valid_q <= result_valid_d;
            max_count_q    <= max_count_d;
            max_index_q    <= max_index_d;
            min_count_q    <= min_count_d;
            min_index_q    <= min_index_d;
`ifdef RANGE_SCAN_SUM_EN
            sum_acc_q      <= sum_acc_d;
            sum_count_q    <= sum_count_d;
`endif
        end
    end

    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        max_acc_d      = max_acc_q;
        max_idx_acc_d  = max_idx_acc_q;
        min_acc_d      = min_acc_q;
        min_idx_acc_d  = min_idx_acc_q;
        result_valid_d = result_valid_q;
        max_count_d    = max_count_q;
        max_index_d    = max_index_q;
        min_count_d    = min_count_q;
        min_index_d    = min_index_q;
`ifdef RANGE_SCAN_SUM_EN
        sum_acc_d      = sum_acc_q;
        sum_count_d    = sum_count_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (range_done) begin
                    state_d        = S_ADDR;
                    idx_d          = '0;
                    result_valid_d = 1'b0;
                    max_acc_d      = '0;
                    max_idx_acc_d  = '0;
                    min_acc_d      = 16'hFFFF;
                    min_idx_acc_d  = '0;
`ifdef RANGE_SCAN_SUM_EN
                    sum_acc_d      = '0;
`endif
                end
            end
            S_ADDR: begin
                state_d = S_PRESENT;
            end
            S_PRESENT: begin
                if (out_ready) begin
                    // Strict compares so ties keep the lowest index.
                    if (rd_count > max_acc_q) begin
                        max_acc_d     = rd_count;
                        max_idx_acc_d = idx_q;
                    end
                    if (rd_count < min_acc_q) begin
                        min_acc_d     = rd_count;
                        min_idx_acc_d = idx_q;
                    end
`ifdef RANGE_SCAN_SUM_EN
                    sum_acc_d = sum_acc_q + {16'h0000, rd_count};
`endif
                    if (idx_q == LAST_IDX) begin
                        state_d = S_FINISH;
                    end else begin
                        idx_d   = idx_q + IDX_ONE;
                        state_d = S_ADDR;
                    end
                end
            end
            S_FINISH: begin
                max_count_d    = max_acc_q;
                max_index_d    = max_idx_acc_q;
                min_count_d    = min_acc_q;
                min_index_d    = min_idx_acc_q;
`ifdef RANGE_SCAN_SUM_EN
                sum_count_d    = sum_acc_q;
`endif
                result_valid_d = 1'b1;
                state_d        = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // rd_addr holds idx through PRESENT so the registered read stays stable under stall.
    always_comb begin
        rd_addr   = '0;
        out_valid = 1'b0;
        out_index = '0;
        out_count = '0;
        busy      = (state_q != S_IDLE);
        if (state_q == S_ADDR || state_q == S_PRESENT) begin
            rd_addr = idx_q;
        end
        if (state_q == S_PRESENT) begin
            out_valid = 1'b1;
            out_index = idx_q;
            out_count = rd_count;
        end
    end

    assign result_valid = result_valid_q;
    assign max_count    = max_count_q;
    assign max_index    = max_index_q;
    assign min_count    = min_count_q;
    assign min_index    = min_index_q;
`ifdef RANGE_SCAN_SUM_EN
    assign sum_count    = sum_count_q;
`endif

endmodule

// File: tb/tb_range_scan.sv
// Directed bench for range_scan: a behavioural registered-read RAM feeds the scanner,
// and every streamed element, the cycle count and the final reductions are checked.
module tb_range_scan;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        range_done;
    logic [3:0]  rd_addr;
    logic [15:0] rd_count;
    logic        busy;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_index;
    logic [15:0] out_count;
    logic        result_valid;
    logic [15:0] max_count;
    logic [3:0]  max_index;
    logic [15:0] min_count;
    logic [3:0]  min_index;
`ifdef RANGE_SCAN_SUM_EN
    logic [31:0] sum_count;
`endif

    logic [15:0] mem [16];
    int          n_vec = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    always_ff @(posedge clk) rd_count <= mem[rd_addr];

    range_scan #(.RAM_WORDS(16), .RAM_ADDR_BITS(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .range_done   (range_done),
        .rd_addr      (rd_addr),
        .rd_count     (rd_count),
        .busy         (busy),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_index    (out_index),
        .out_count    (out_count),
        .result_valid (result_valid),
        .max_count    (max_count),
        .max_index    (max_index),
        .min_count    (min_count),
        .min_index    (min_index)
`ifdef RANGE_SCAN_SUM_EN
        ,
        .sum_count    (sum_count)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_vec++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic chk_idle_zero(input string tag);
        chk({tag, "_busy"},   32'(busy), 32'd0);
        chk({tag, "_valid"},  32'(out_valid), 32'd0);
        chk({tag, "_index"},  32'(out_index), 32'd0);
        chk({tag, "_count"},  32'(out_count), 32'd0);
        chk({tag, "_rdaddr"}, 32'(rd_addr), 32'd0);
        chk({tag, "_rvalid"}, 32'(result_valid), 32'd0);
        chk({tag, "_max"},    32'(max_count), 32'd0);
        chk({tag, "_min"},    32'(min_count), 32'd0);
`ifdef RANGE_SCAN_SUM_EN
        chk({tag, "_sum"},    sum_count, 32'd0);
`endif
    endtask

    // stall=1 drives out_ready as the repeating 0,0,1 pattern aligned to the scan start.
    task automatic scan(input string tag, input int stall, input int redo_at, input int rst_at,
                        input int exp_cycles, input logic [15:0] emax, input logic [3:0] emaxi,
                        input logic [15:0] emin, input logic [3:0] emini, input logic [31:0] esum);
        int  k;
        int  exp_idx;
        logic nr;
        @(negedge clk);
        range_done = 1'b1;
        out_ready  = 1'b0;
        @(negedge clk);
        range_done = 1'b0;
        k       = 0;
        exp_idx = 0;
        while (k < 200 && !result_valid) begin
            range_done = 1'b0;
            if (out_valid) begin
                chk({tag, "_idx"}, 32'(out_index), 32'(exp_idx));
                chk({tag, "_cnt"}, 32'(out_count), 32'(mem[exp_idx[3:0]]));
                if (rst_at == exp_idx) begin
                    rst_n = 1'b0;
                    #1;
                    chk_idle_zero({tag, "_rst"});
                    @(negedge clk);
                    rst_n = 1'b1;
                    out_ready = 1'b0;
                    return;
                end
                if (redo_at == exp_idx) range_done = 1'b1;
            end else begin
                chk({tag, "_busy"}, 32'(busy), 32'd1);
            end
            nr = (stall != 0) ? (((k + 1) % 3) == 0) : 1'b1;
            out_ready = nr;
            if (out_valid && nr) exp_idx++;
            @(negedge clk);
            k++;
        end
        out_ready = 1'b0;
        chk({tag, "_cycles"},  32'(k), 32'(exp_cycles));
        chk({tag, "_nelem"},   32'(exp_idx), 32'd16);
        chk({tag, "_rvalid"},  32'(result_valid), 32'd1);
        chk({tag, "_busyend"}, 32'(busy), 32'd0);
        chk({tag, "_max"},     32'(max_count), 32'(emax));
        chk({tag, "_maxi"},    32'(max_index), 32'(emaxi));
        chk({tag, "_min"},     32'(min_count), 32'(emin));
        chk({tag, "_mini"},    32'(min_index), 32'(emini));
`ifdef RANGE_SCAN_SUM_EN
        chk({tag, "_sum"},     sum_count, esum);
`endif
        if (esum == 32'hFFFF_FFFF) $display("unreachable sum marker");
        @(negedge clk);
        chk({tag, "_hold"},    32'(result_valid), 32'd1);
    endtask

    initial begin
        rst_n      = 1'b0;
        range_done = 1'b0;
        out_ready  = 1'b0;
        for (int i = 0; i < 16; i++) mem[i] = 16'(i + 1);
        #1;
        chk_idle_zero("reset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        scan("ramp", 0, -1, -1, 33, 16'd16, 4'd15, 16'd1, 4'd0, 32'd136);

        mem[0] = 16'd7; mem[1] = 16'd20; mem[2] = 16'd20; mem[15] = 16'd7;
        for (int i = 3; i < 15; i++) mem[i] = 16'd3;
        scan("ties", 0, -1, -1, 33, 16'd20, 4'd1, 16'd3, 4'd3, 32'd90);

        for (int i = 0; i < 16; i++) mem[i] = 16'(i + 1);
        scan("stall", 1, -1, -1, 49, 16'd16, 4'd15, 16'd1, 4'd0, 32'd136);
        scan("redo", 0, 5, -1, 33, 16'd16, 4'd15, 16'd1, 4'd0, 32'd136);
        scan("midrst", 0, -1, 8, 0, 16'd0, 4'd0, 16'd0, 4'd0, 32'd0);
        chk("postrst_rvalid", 32'(result_valid), 32'd0);
        scan("fresh", 0, -1, -1, 33, 16'd16, 4'd15, 16'd1, 4'd0, 32'd136);

        for (int i = 0; i < 16; i++) mem[i] = 16'hFFFF;
        scan("allmax", 0, -1, -1, 33, 16'hFFFF, 4'd0, 16'hFFFF, 4'd0, 32'h000F_FFF0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
